// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: transfer types,
// condition codes, PSR bit positions and the sequencer state enum.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    XFER_SEQ   = 2'b00,
    XFER_BCOND = 2'b01,
    XFER_JCOND = 2'b10,
    XFER_JAL   = 2'b11
  } xfer_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_HI = 4'h4,
    COND_LS = 4'h5,
    COND_GT = 4'h6,
    COND_LE = 4'h7,
    COND_FS = 4'h8,
    COND_FC = 4'h9,
    COND_LO = 4'hA,
    COND_HS = 4'hB,
    COND_LT = 4'hC,
    COND_GE = 4'hD,
    COND_UC = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  // PSR bit indices
  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a conditional
// transfer is taken given the 4-bit condition and the PSR flags.
module cond_eval
  import pc_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [7:0] flags,
  output logic       cond_true
);

  logic c_flag, l_flag, f_flag, z_flag, n_flag;
  // PSR bits 1, 3 and 4 carry no condition meaning
  logic unused_flags;

  assign c_flag = flags[PSR_C];
  assign l_flag = flags[PSR_L];
  assign f_flag = flags[PSR_F];
  assign z_flag = flags[PSR_Z];
  assign n_flag = flags[PSR_N];
  assign unused_flags = ^{flags[4:3], flags[1]};

  // Decode the condition against the selected flags
  always_comb begin
    cond_true = 1'b0;
    case (cond_t'(cond))
      COND_EQ: cond_true = z_flag;
      COND_NE: cond_true = !z_flag;
      COND_CS: cond_true = c_flag;
      COND_CC: cond_true = !c_flag;
      COND_HI: cond_true = l_flag;
      COND_LS: cond_true = !l_flag;
      COND_GT: cond_true = n_flag;
      COND_LE: cond_true = !n_flag;
      COND_FS: cond_true = f_flag;
      COND_FC: cond_true = !f_flag;
      COND_LO: cond_true = !l_flag && !z_flag;
      COND_HS: cond_true = l_flag || z_flag;
      COND_LT: cond_true = !n_flag && !z_flag;
      COND_GE: cond_true = n_flag || z_flag;
      COND_UC: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT state machine that steps the
// fetch address, applies relative branches, absolute jumps and
// jump-and-link, and reports redirects as one-cycle pulses.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DISP_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [1:0]        xfer_type,
  input  logic [3:0]        cond,
  input  logic [7:0]        flags,
  input  logic [DISP_W-1:0] disp,
  input  logic [ADDR_W-1:0] target,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              taken,
  output logic [ADDR_W-1:0] link,
  output logic              link_valid,
  output logic              halted
);

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [ADDR_W-1:0]   link_reg;
  logic                pc_valid_reg;
  logic                taken_reg;
  logic                link_valid_reg;
  logic                halted_reg;

  logic                cond_true;
  xfer_t               xfer;
  logic signed [DISP_W-1:0] disp_s;
  logic [ADDR_W-1:0]   disp_ext;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   pc_branch;

  cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true)
  );

  // Address arithmetic wraps naturally at ADDR_W bits
  assign xfer      = xfer_t'(xfer_type);
  assign disp_s    = signed'(disp);
  assign disp_ext  = ADDR_W'(disp_s);
  assign pc_inc    = pc_reg + ADDR_W'(1);
  assign pc_branch = pc_reg + disp_ext;

  // Sequencer state machine; every output is a register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_BOOT;
      pc_reg         <= RESET_VEC;
      link_reg       <= '0;
      pc_valid_reg   <= 1'b0;
      taken_reg      <= 1'b0;
      link_valid_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      // Pulses default low; only a redirecting edge raises them
      taken_reg      <= 1'b0;
      link_valid_reg <= 1'b0;
      case (state_reg)
        ST_BOOT: begin
          state_reg    <= ST_RUN;
          pc_valid_reg <= 1'b1;
        end
        ST_RUN: begin
          if (stall) begin
            // hold everything
          end else if (halt) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else if (instr_valid) begin
            case (xfer)
              XFER_SEQ: pc_reg <= pc_inc;
              XFER_BCOND: begin
                if (cond_true) begin
                  pc_reg    <= pc_branch;
                  taken_reg <= 1'b1;
                end else begin
                  pc_reg <= pc_inc;
                end
              end
              XFER_JCOND: begin
                if (cond_true) begin
                  pc_reg    <= target;
                  taken_reg <= 1'b1;
                end else begin
                  pc_reg <= pc_inc;
                end
              end
              XFER_JAL: begin
                pc_reg         <= target;
                link_reg       <= pc_inc;
                link_valid_reg <= 1'b1;
                taken_reg      <= 1'b1;
              end
              default: pc_reg <= pc_inc;
            endcase
          end
        end
        ST_HALT: begin
          // A simultaneous halt request keeps the sequencer parked
          if (resume && !halt) begin
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_BOOT;
          pc_reg       <= RESET_VEC;
          pc_valid_reg <= 1'b0;
          halted_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = pc_reg;
  assign pc_valid   = pc_valid_reg;
  assign taken      = taken_reg;
  assign link       = link_reg;
  assign link_valid = link_valid_reg;
  assign halted     = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset/boot, a vector table of single
// transfers, a full condition/flag sweep, and stall/halt/reset sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [1:0]  xfer_type;
  logic [3:0]  cond;
  logic [7:0]  flags;
  logic [15:0] disp;
  logic [15:0] target;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [15:0] pc;
  logic        pc_valid;
  logic        taken;
  logic [15:0] link;
  logic        link_valid;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(16), .DISP_W(16), .RESET_VEC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .xfer_type   (xfer_type),
    .cond        (cond),
    .flags       (flags),
    .disp        (disp),
    .target      (target),
    .stall       (stall),
    .halt        (halt),
    .resume      (resume),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .taken       (taken),
    .link        (link),
    .link_valid  (link_valid),
    .halted      (halted)
  );

  typedef struct {
    logic [1:0]  xfer;
    logic [3:0]  cnd;
    logic [7:0]  flg;
    logic [15:0] dsp;
    logic [15:0] tgt;
    logic [15:0] start_pc;
    logic [15:0] exp_pc;
    logic        exp_taken;
    logic        exp_lv;
    logic [15:0] exp_link;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [1:0] x, input logic [3:0] c, input logic [7:0] f,
                      input logic [15:0] d, input logic [15:0] t);
    xfer_type   = x;
    cond        = c;
    flags       = f;
    disp        = d;
    target      = t;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  function automatic bit model_cond(input int c, input bit cf, input bit lf,
                                    input bit ff, input bit zf, input bit nf);
    case (c)
      0:  return zf;
      1:  return !zf;
      2:  return cf;
      3:  return !cf;
      4:  return lf;
      5:  return !lf;
      6:  return nf;
      7:  return !nf;
      8:  return ff;
      9:  return !ff;
      10: return !lf && !zf;
      11: return lf || zf;
      12: return !nf && !zf;
      13: return nf || zf;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  vec_t vecs[10];
  logic [15:0] exp_pc;

  initial begin
    // xfer, cond, flags, disp, target, start, exp_pc, taken, link_valid, link
    vecs[0] = '{2'b01, 4'h0, 8'h40, 16'hFFFC, 16'h0000, 16'h0010, 16'h000C, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{2'b01, 4'h0, 8'h00, 16'hFFFC, 16'h0000, 16'h0010, 16'h0011, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{2'b00, 4'hE, 8'h00, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{2'b01, 4'hE, 8'h00, 16'h0005, 16'h0000, 16'hFFFE, 16'h0003, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{2'b11, 4'hF, 8'h00, 16'h0000, 16'h0100, 16'h0020, 16'h0100, 1'b1, 1'b1, 16'h0021};
    vecs[5] = '{2'b10, 4'hF, 8'h00, 16'h0000, 16'h5555, 16'h0100, 16'h0101, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{2'b10, 4'hA, 8'h00, 16'h0000, 16'h1234, 16'h0050, 16'h1234, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{2'b10, 4'hB, 8'h00, 16'h0000, 16'h1234, 16'h0050, 16'h0051, 1'b0, 1'b0, 16'h0000};
    vecs[8] = '{2'b01, 4'hD, 8'h80, 16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    vecs[9] = '{2'b11, 4'hF, 8'h00, 16'h0000, 16'hABCD, 16'h1233, 16'hABCD, 1'b1, 1'b1, 16'h1234};

    reset = 1'b1; instr_valid = 1'b0; xfer_type = 2'b00; cond = 4'h0; flags = 8'h00;
    disp = 16'h0000; target = 16'h0000; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    tick();
    tick();
    check("reset_pc", pc, 16'h0000);
    check("reset_pc_valid", pc_valid, 0);
    check("reset_halted", halted, 0);
    check("reset_link", link, 16'h0000);

    // BOOT cycle, then RUN
    reset = 1'b0;
    tick();
    check("boot_exit_pc_valid", pc_valid, 1);
    check("boot_exit_pc", pc, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      exec(2'b00, 4'h0, 8'h00, 16'h0000, 16'h0000);
      check("seq_pc", pc, 32'(i));
      check("seq_taken", taken, 0);
      $display("seq step %0d: pc=%04h taken=%0b", i, pc, taken);
    end
    // idle holds pc
    tick();
    check("idle_pc", pc, 16'h0003);

    // Table-driven single transfers
    for (int i = 0; i < 10; i++) begin
      exec(2'b10, 4'hE, 8'h00, 16'h0000, vecs[i].start_pc);
      check("vec_setup_pc", pc, vecs[i].start_pc);
      exec(vecs[i].xfer, vecs[i].cnd, vecs[i].flg, vecs[i].dsp, vecs[i].tgt);
      $display("vec %0d: start=%04h pc=%04h taken=%0b link_valid=%0b link=%04h",
               i, vecs[i].start_pc, pc, taken, link_valid, link);
      check("vec_pc", pc, vecs[i].exp_pc);
      check("vec_taken", taken, vecs[i].exp_taken);
      check("vec_link_valid", link_valid, vecs[i].exp_lv);
      if (vecs[i].exp_lv) check("vec_link", link, vecs[i].exp_link);
      tick();
      check("vec_taken_pulse", taken, 0);
      check("vec_lv_pulse", link_valid, 0);
      check("vec_idle_pc", pc, vecs[i].exp_pc);
    end

    // Condition sweep: every cond against every combination of 5 flags
    exec(2'b10, 4'hE, 8'h00, 16'h0000, 16'h0400);
    exp_pc = 16'h0400;
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 32; k++) begin
        logic [7:0] f;
        bit t;
        f = 8'h00;
        f[0] = k[0]; f[2] = k[1]; f[5] = k[2]; f[6] = k[3]; f[7] = k[4];
        f[4] = k[0] ^ k[3]; f[1] = k[2]; f[3] = k[1] ^ k[4];
        t = model_cond(c, k[0], k[1], k[2], k[3], k[4]);
        exec(2'b01, 4'(c), f, 16'h0002, 16'h0000);
        exp_pc = exp_pc + (t ? 16'h0002 : 16'h0001);
        check($sformatf("sweep_c%0d_f%0d_pc", c, k), pc, exp_pc);
        check($sformatf("sweep_c%0d_f%0d_taken", c, k), taken, t);
      end
      $display("sweep cond %0h done: pc=%04h", c, pc);
    end
    check("link_held", link, 16'h1234);

    // stall and halt together: stall wins
    stall = 1'b1; halt = 1'b1; instr_valid = 1'b1; xfer_type = 2'b11; target = 16'h0999;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stallhalt_pc", pc, exp_pc);
      check("stallhalt_halted", halted, 0);
      check("stallhalt_lv", link_valid, 0);
      check("stallhalt_taken", taken, 0);
    end
    // halt alone enters HALT without executing
    stall = 1'b0;
    tick();
    check("halt_halted", halted, 1);
    check("halt_pc", pc, exp_pc);
    check("halt_pc_valid", pc_valid, 1);
    check("halt_link", link, 16'h1234);
    halt = 1'b0; xfer_type = 2'b10; cond = 4'hE; target = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      stall = i[0];
      tick();
      check("halted_ignore_pc", pc, exp_pc);
      check("halted_ignore_taken", taken, 0);
      check("halted_stays", halted, 1);
    end
    instr_valid = 1'b0; stall = 1'b0;
    halt = 1'b1; resume = 1'b1;
    tick();
    check("halt_resume_stays", halted, 1);
    halt = 1'b0;
    tick();
    resume = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_pc", pc, exp_pc);
    exec(2'b00, 4'h0, 8'h00, 16'h0000, 16'h0000);
    check("resume_run_pc", pc, exp_pc + 16'h0001);
    $display("halt sequence done: pc=%04h halted=%0b", pc, halted);

    // reset during HALT
    halt = 1'b1;
    tick();
    check("rehalt", halted, 1);
    reset = 1'b1; instr_valid = 1'b1; xfer_type = 2'b11; resume = 1'b1;
    tick();
    check("rst_halt_pc", pc, 16'h0000);
    check("rst_halt_halted", halted, 0);
    check("rst_halt_pc_valid", pc_valid, 0);
    check("rst_halt_link", link, 16'h0000);
    reset = 1'b0; halt = 1'b0; resume = 1'b0; instr_valid = 1'b0;
    check("boot_pc_valid", pc_valid, 0);
    tick();
    check("boot_done_pc_valid", pc_valid, 1);
    check("boot_done_pc", pc, 16'h0000);
    $display("reset from halt done: pc=%04h pc_valid=%0b", pc, pc_valid);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
